snake_track: RTL and testbench

SNAKE_TRACK -- requirements
Module: snake_track

---
 rtl/snake_track.sv | 169 ++++++++++++++++
 tb/tb_snake_track.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_track.sv
// snake_track: ring-buffered snake segment tracker with a move/self-collision FSM
// and registered scan-pixel head/body hit outputs.
module snake_track #(
  parameter int MAX_LEN = 32,
  parameter int SEG     = 5,
  parameter int STEP    = 5,
  parameter int X_MAX   = 640,
  parameter int Y_MAX   = 480,
  parameter int WRAP    = 0
) (
  input  logic                       VGA_clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       update,
  input  logic [3:0]                 dir,
  input  logic                       grow,
  input  logic [9:0]                 xCount,
  input  logic [9:0]                 yCount,
  output logic                       snakeHead,
  output logic                       snakeBody,
  output logic [$clog2(MAX_LEN):0]   size,
  output logic                       dead,
  output logic                       busy
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int SW = PW + 1;
  localparam logic [10:0] XM = 11'(X_MAX);
  localparam logic [10:0] YM = 11'(Y_MAX);
  localparam logic [10:0] ST = 11'(STEP);
  localparam logic [10:0] SG = 11'(SEG);
  localparam logic [9:0] ST10 = 10'(STEP);
  localparam logic [9:0] XW = 10'(X_MAX - STEP);
  localparam logic [9:0] YW = 10'(Y_MAX - STEP);
  localparam logic [SW-1:0] ML = SW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DEAD} state_t;

  state_t          r_st;
  logic [9:0]      r_x [MAX_LEN];
  logic [9:0]      r_y [MAX_LEN];
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_k;
  logic [SW-1:0]   r_size;
  logic [3:0]      r_hd;
  logic [3:0]      r_nd;
  logic            r_gp;
  logic            r_up;
  logic            r_head;
  logic            r_body;

  logic [10:0]     w_hx, w_hy, w_xp, w_yp;
  logic [9:0]      w_xm, w_ym, w_nx, w_ny;
  logic [PW-1:0]   w_nptr, w_kp;
  logic [3:0]      w_cur;
  logic            w_live, w_move, w_wall, w_dir_ok, w_match, w_last;
  logic            w_head, w_body;
  logic [PW-1:0]   w_k [MAX_LEN];
  logic            w_in [MAX_LEN];

  assign w_hx = {1'b0, r_x[r_ptr]};
  assign w_hy = {1'b0, r_y[r_ptr]};
  assign w_xp = w_hx + ST;
  assign w_yp = w_hy + ST;
  assign w_xm = r_x[r_ptr] - ST10;
  assign w_ym = r_y[r_ptr] - ST10;
  assign w_nptr = r_ptr + 1'b1;
  assign w_live = (r_st == RUN) || (r_st == CHECK);
  assign w_move = (r_st == RUN) && (update || r_up) && (|r_nd);
  // heading bits {right,down,left,up}; reject the reverse of the heading in force after this edge
  assign w_cur = w_move ? r_nd : r_hd;
  assign w_dir_ok = $onehot(dir) && (dir != {w_cur[1], w_cur[0], w_cur[3], w_cur[2]});
  assign w_wall = (WRAP == 0) && ((r_nd[3] && (w_xp + SG > XM)) || (r_nd[1] && (w_hx < ST)) ||
                                  (r_nd[2] && (w_yp + SG > YM)) || (r_nd[0] && (w_hy < ST)));
  assign w_nx = r_nd[3] ? ((w_xp >= XM) ? 10'd0 : w_xp[9:0]) :
                r_nd[1] ? ((w_hx < ST) ? XW : w_xm) : r_x[r_ptr];
  assign w_ny = r_nd[2] ? ((w_yp >= YM) ? 10'd0 : w_yp[9:0]) :
                r_nd[0] ? ((w_hy < ST) ? YW : w_ym) : r_y[r_ptr];
  assign w_kp = r_ptr - r_k;
  assign w_match = (r_size > SW'(1)) && (r_x[r_ptr] == r_x[w_kp]) && (r_y[r_ptr] == r_y[w_kp]);
  assign w_last = ({1'b0, r_k} + 1'b1) >= r_size;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
    assign w_k[g] = r_ptr - PW'(g);
    assign w_in[g] = ({1'b0, xCount} >= {1'b0, r_x[g]}) && ({1'b0, xCount} < {1'b0, r_x[g]} + SG) &&
                     ({1'b0, yCount} >= {1'b0, r_y[g]}) && ({1'b0, yCount} < {1'b0, r_y[g]} + SG);
  end

  always_comb begin
    w_head = 1'b0;
    w_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_head = w_head | (w_in[i] && (w_k[i] == '0));
      w_body = w_body | (w_in[i] && (w_k[i] != '0) && ({1'b0, w_k[i]} < r_size));
    end
  end

  always_ff @(posedge VGA_clk or negedge reset) begin
    if (!reset) begin
      r_st   <= IDLE;
      r_ptr  <= '0;
      r_k    <= '0;
      r_size <= SW'(1);
      r_hd   <= '0;
      r_nd   <= '0;
      r_gp   <= 1'b0;
      r_up   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_x[i] <= 10'd300;
        r_y[i] <= 10'd300;
      end
    end else if (!start) begin
      r_st   <= IDLE;
      r_ptr  <= '0;
      r_k    <= '0;
      r_size <= SW'(1);
      r_hd   <= '0;
      r_nd   <= '0;
      r_gp   <= 1'b0;
      r_up   <= 1'b0;
      r_x[0] <= 10'd300;
      r_y[0] <= 10'd300;
    end else begin
      if (w_live && w_dir_ok) r_nd <= dir;
      if (w_live && grow) r_gp <= 1'b1;
      case (r_st)
        IDLE: r_st <= RUN;
        RUN: begin
          if (update || r_up) r_up <= 1'b0;
          if (w_move) begin
            if (w_wall) r_st <= DEAD;
            else begin
              r_x[w_nptr] <= w_nx;
              r_y[w_nptr] <= w_ny;
              r_ptr  <= w_nptr;
              r_hd   <= r_nd;
              r_size <= r_size + SW'(r_gp && (r_size != ML));
              r_gp   <= grow;
              r_k    <= PW'(1);
              r_st   <= CHECK;
            end
          end
        end
        CHECK: begin
          if (update) r_up <= 1'b1;
          if (w_match) r_st <= DEAD;
          else if (w_last) r_st <= RUN;
          else r_k <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge VGA_clk or negedge reset) begin
    if (!reset) begin
      r_head <= 1'b0;
      r_body <= 1'b0;
    end else begin
      r_head <= w_head;
      r_body <= w_body;
    end
  end

  assign snakeHead = r_head;
  assign snakeBody = r_body;
  assign size = r_size;
  assign dead = (r_st == DEAD);
  assign busy = (r_st == CHECK);
endmodule

// File: tb/tb_snake_track.sv
// tb_snake_track: directed scenario bench for snake_track; a WRAP=0 and a WRAP=1
// instance share all inputs so wall death and wrap-around can be compared.
module tb_snake_track;
  logic       clk = 1'b0;
  logic       reset, start, update, grow;
  logic [3:0] dir;
  logic [9:0] xc, yc;
  logic       h0, b0, d0, bz0, h1, b1, d1, bz1;
  logic [5:0] s0, s1;
  int         n_chk = 0;
  int         n_fail = 0;

  localparam logic [3:0] R = 4'b1000, D = 4'b0100, L = 4'b0010, U = 4'b0001;

  always #5 clk = ~clk;

  snake_track #(.WRAP(0)) u0 (
    .VGA_clk(clk), .reset(reset), .start(start), .update(update), .dir(dir), .grow(grow),
    .xCount(xc), .yCount(yc), .snakeHead(h0), .snakeBody(b0), .size(s0), .dead(d0), .busy(bz0)
  );

  snake_track #(.WRAP(1)) u1 (
    .VGA_clk(clk), .reset(reset), .start(start), .update(update), .dir(dir), .grow(grow),
    .xCount(xc), .yCount(yc), .snakeHead(h1), .snakeBody(b1), .size(s1), .dead(d1), .busy(bz1)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input int x, input int y);
    xc = 10'(x);
    yc = 10'(y);
    tick(1);
  endtask

  task automatic set_dir(input logic [3:0] d);
    dir = d;
    tick(1);
    dir = '0;
  endtask

  // pulse update, then count cycles with busy observed high (bounded)
  task automatic move(output int nb);
    update = 1'b1;
    tick(1);
    update = 1'b0;
    nb = 0;
    while (bz0 && nb < 100) begin
      nb++;
      tick(1);
    end
    if (nb >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, want 0", bz0, nb);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; update = 1'b0; grow = 1'b0; dir = '0;
    xc = 10'd300; yc = 10'd300;
    tick(2);
    n_chk++; if (h0 !== 1'b0) begin n_fail++; $display("FAIL reset_head: got %b want 0", h0); end
    n_chk++; if (d0 !== 1'b0 || bz0 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: dead %b busy %b want 0 0", d0, bz0); end
    n_chk++; if (s0 !== 6'd1) begin n_fail++; $display("FAIL reset_size: got %0d want 1", s0); end
    reset = 1'b1;
    tick(1);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL idle_head_300: got %b want 1", h0); end
    n_chk++; if (b0 !== 1'b0) begin n_fail++; $display("FAIL idle_body: got %b want 0", b0); end
    probe(305, 300);
    n_chk++; if (h0 !== 1'b0) begin n_fail++; $display("FAIL head_x_edge_305: got %b want 0", h0); end
    probe(304, 304);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL head_corner_304: got %b want 1", h0); end
    probe(300, 305);
    n_chk++; if (h0 !== 1'b0) begin n_fail++; $display("FAIL head_y_edge_305: got %b want 0", h0); end
  endtask

  task automatic test_move;
    int nb;
    start = 1'b1;
    tick(1);
    set_dir(R);
    for (int i = 0; i < 3; i++) begin
      move(nb);
      n_chk++; if (nb !== 1) begin n_fail++; $display("FAIL move_busy_len %0d: got %0d want 1", i, nb); end
    end
    probe(315, 300);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL move_head_315: got %b want 1", h0); end
    probe(314, 300);
    n_chk++; if (h0 !== 1'b0 || b0 !== 1'b0) begin n_fail++; $display("FAIL move_314: head %b body %b want 0 0", h0, b0); end
    n_chk++; if (s0 !== 6'd1) begin n_fail++; $display("FAIL move_size: got %0d want 1", s0); end
  endtask

  task automatic test_grow;
    int nb;
    for (int i = 1; i <= 4; i++) begin
      grow = 1'b1;
      tick(1);
      grow = 1'b0;
      move(nb);
      n_chk++; if (nb !== i) begin n_fail++; $display("FAIL grow_busy_len %0d: got %0d want %0d", i, nb, i); end
    end
    n_chk++; if (s0 !== 6'd5) begin n_fail++; $display("FAIL grow_size: got %0d want 5", s0); end
    probe(335, 300);
    n_chk++; if (h0 !== 1'b1 || b0 !== 1'b0) begin n_fail++; $display("FAIL grow_head_335: head %b body %b want 1 0", h0, b0); end
    probe(315, 300);
    n_chk++; if (h0 !== 1'b0 || b0 !== 1'b1) begin n_fail++; $display("FAIL grow_tail_315: head %b body %b want 0 1", h0, b0); end
    probe(327, 303);
    n_chk++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL grow_body_327: got %b want 1", b0); end
    probe(340, 300);
    n_chk++; if (h0 !== 1'b0 || b0 !== 1'b0) begin n_fail++; $display("FAIL grow_ahead_340: head %b body %b want 0 0", h0, b0); end
  endtask

  task automatic test_reverse;
    int nb;
    set_dir(L);
    set_dir(4'b0101);
    move(nb);
    move(nb);
    probe(345, 300);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL reverse_head_345: got %b want 1", h0); end
    probe(330, 300);
    n_chk++; if (h0 !== 1'b0 || b0 !== 1'b1) begin n_fail++; $display("FAIL reverse_330: head %b body %b want 0 1", h0, b0); end
  endtask

  task automatic test_loop;
    int nb;
    set_dir(U);
    move(nb);
    set_dir(L);
    move(nb);
    n_chk++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL loop_alive: dead %b want 0", d0); end
    set_dir(D);
    move(nb);
    n_chk++; if (nb !== 4) begin n_fail++; $display("FAIL loop_busy_len: got %0d want 4", nb); end
    n_chk++; if (d0 !== 1'b1) begin n_fail++; $display("FAIL loop_dead: got %b want 1", d0); end
    set_dir(R);
    move(nb);
    n_chk++; if (nb !== 0 || d0 !== 1'b1) begin n_fail++; $display("FAIL dead_frozen: busy len %0d dead %b want 0 1", nb, d0); end
    probe(340, 300);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL dead_head_340: got %b want 1", h0); end
    n_chk++; if (s0 !== 6'd5) begin n_fail++; $display("FAIL dead_size: got %0d want 5", s0); end
    start = 1'b0;
    tick(1);
    n_chk++; if (d0 !== 1'b0 || s0 !== 6'd1) begin n_fail++; $display("FAIL restart_idle: dead %b size %0d want 0 1", d0, s0); end
    probe(300, 300);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL restart_head_300: got %b want 1", h0); end
  endtask

  task automatic test_wall;
    int nb;
    start = 1'b1;
    tick(1);
    set_dir(L);
    for (int i = 0; i < 60; i++) move(nb);
    probe(0, 300);
    n_chk++; if (h0 !== 1'b1 || h1 !== 1'b1) begin n_fail++; $display("FAIL wall_at_0: head0 %b head1 %b want 1 1", h0, h1); end
    move(nb);
    n_chk++; if (d0 !== 1'b1 || nb !== 0) begin n_fail++; $display("FAIL wall_dead: dead %b busy len %0d want 1 0", d0, nb); end
    n_chk++; if (d1 !== 1'b0) begin n_fail++; $display("FAIL wrap_alive: dead %b want 0", d1); end
    probe(0, 300);
    n_chk++; if (h0 !== 1'b1 || h1 !== 1'b0) begin n_fail++; $display("FAIL wall_0_after: head0 %b head1 %b want 1 0", h0, h1); end
    probe(635, 300);
    n_chk++; if (h0 !== 1'b0 || h1 !== 1'b1) begin n_fail++; $display("FAIL wrap_635: head0 %b head1 %b want 0 1", h0, h1); end
  endtask

  task automatic test_back_to_back;
    int nb;
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    set_dir(R);
    for (int i = 0; i < 2; i++) begin
      grow = 1'b1;
      tick(1);
      grow = 1'b0;
      move(nb);
    end
    update = 1'b1;
    tick(3);
    update = 1'b0;
    n_chk++; if (bz0 !== 1'b0) begin n_fail++; $display("FAIL b2b_run_gap: busy %b want 0", bz0); end
    tick(1);
    n_chk++; if (bz0 !== 1'b1) begin n_fail++; $display("FAIL b2b_latched_move: busy %b want 1", bz0); end
    nb = 0;
    while (bz0 && nb < 100) begin
      nb++;
      tick(1);
    end
    n_chk++; if (nb !== 2) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want 2", nb); end
    probe(320, 300);
    n_chk++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL b2b_head_320: got %b want 1", h0); end
    probe(325, 300);
    n_chk++; if (h0 !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third_325: got %b want 0", h0); end
    n_chk++; if (s0 !== 6'd3) begin n_fail++; $display("FAIL b2b_size: got %0d want 3", s0); end
    xc = 10'd320; yc = 10'd300;
    update = 1'b1;
    tick(1);
    update = 1'b0;
    n_chk++; if (bz0 !== 1'b1) begin n_fail++; $display("FAIL abort_in_check: busy %b want 1", bz0); end
    reset = 1'b0;
    #1;
    n_chk++; if (bz0 !== 1'b0 || d0 !== 1'b0) begin n_fail++; $display("FAIL abort_flags: busy %b dead %b want 0 0", bz0, d0); end
    n_chk++; if (s0 !== 6'd1 || h0 !== 1'b0) begin n_fail++; $display("FAIL abort_state: size %0d head %b want 1 0", s0, h0); end
    tick(1);
    reset = 1'b1;
    probe(300, 300);
    n_chk++; if (h0 !== 1'b1 || d0 !== 1'b0) begin n_fail++; $display("FAIL abort_recover: head %b dead %b want 1 0", h0, d0); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_grow();
    test_reverse();
    test_loop();
    test_wall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
